bus_slave_regs_if: RTL and testbench
====================================

// Module: bus_slave_regs_if
// PURPOSE
//  Bus responder (slave end) of the shared master/slave bus: answers the bus_req_/grnt_ master
//  protocol driven by CPU bus interfaces. Decodes chip select + address strobe, latches the
//  request, inserts WAIT_CYCLES wait states, then returns a one-cycle active-low ready with read
//  data. Backs a small 32-bit register bank; reg 0 exported as control, reg 1 a read-only status.
// PARAMETERS
//  ADDR_W       3  word-index width; bank holds 2**ADDR_W 32-bit words
//  WAIT_CYCLES  1  wait states between strobe and ready (0 allowed)
//  WAIT_W       4  wait counter width; WAIT_CYCLES < 2**WAIT_W
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset_       in   1   asynchronous, active-low reset
//  bus_cs_      in   1   chip select from bus address decoder, active low
//  bus_as_      in   1   address strobe, active low, one cycle per transfer
//  bus_rw       in   1   `READ / `WRITE
//  bus_addr     in   32  byte address; word index = bus_addr[ADDR_W+1:2], rest ignored
//  bus_wr_data  in   32  write data, held by master until ready
//  bus_rd_data  out  32  read data; 0 whenever bus_rdy_ is high (OR-mux safe)
//  bus_rdy_     out  1   ready, active low, exactly one cycle per accepted transfer
//  stat_in      in   32  status word returned on reads of index 1
//  ctrl_out     out  32  current value of register index 0
//  proto_err    out  1   sticky: strobe received while not IDLE
// BEHAVIOUR
//  Reset (async, reset_=0): state IDLE, bus_rdy_=1, bus_rd_data=0, all bank words 0,
//   ctrl_out=0, proto_err=0, wait counter 0, latched request cleared. Outputs change at once.
//  Accept: in IDLE, edge with bus_cs_=0 && bus_as_=0 latches index, rw, wr_data.
//   WAIT_CYCLES=0 -> RESPOND; else WAIT with counter loaded to WAIT_CYCLES-1.
//  WAIT: counter decrements each edge; at 0 -> RESPOND. cs_/rw/addr not re-sampled.
//  Entering RESPOND (same edge): write commits to bank (index 1 writes discarded); read loads
//   registered bus_rd_data from bank, or stat_in for index 1. Write leaves bus_rd_data 0.
//  RESPOND: bus_rdy_=0 for exactly one cycle; next edge -> IDLE, bus_rdy_=1, bus_rd_data=0.
//  Latency: strobe cycle + WAIT_CYCLES cycles, then ready cycle (ready in cycle WAIT_CYCLES+1).
//  Back-to-back: new strobe accepted only in IDLE; strobe with cs_=0 in WAIT/RESPOND is ignored
//   and sets proto_err (cleared only by reset). Strobe with cs_=1 never accepted, no error.
//  Read-after-write to same index returns new value (bank updated before the read's RESPOND).
//  ctrl_out follows bank word 0 directly (updated on the committing edge).
//  Reset mid-transfer: transfer abandoned, no write committed, no ready issued.
//  Byte lanes: whole-word access only; bus_addr[1:0] ignored.
// STRUCTURE
//  Shared header (bus_head.v): `BUS_SLAVE_IF_STATE_IDLE/WAIT/RESPOND (2-bit), `SLV_REG_CTRL=0,
//   `SLV_REG_STAT=1; reuse `READ/`WRITE, `ENABLE_/`DISABLE_, `WORD_DATA_W from existing headers.
//  Sub-module bus_slave_regbank: 2**ADDR_W x 32 bank, one write port, one read port, excludes
//   write to STAT index, exposes word 0. FSM/wait counter/handshake stay in top.
// TESTING
//  WAIT_CYCLES=1: write 0xDEADBEEF to 0x0000_0000 -> bus_rdy_ low in cycle 2 only, ctrl_out=0xDEADBEEF.
//  Read 0x0000_0000 after above -> bus_rd_data=0xDEADBEEF exactly while bus_rdy_=0, 0 otherwise.
//  stat_in=0x1234_5678, write 0xFFFF_FFFF then read 0x0000_0004 -> read returns 0x1234_5678.
//  WAIT_CYCLES=0 and =3: read 0x0000_001C -> ready in cycle 1 / cycle 4 after strobe, one cycle wide.
//  Second strobe (cs_=0) during WAIT -> ignored, single ready, proto_err=1 until reset_.
//  reset_ low during WAIT of write 0xA5A5_A5A5 to index 2 -> no ready; later read of index 2 = 0.

Source files
------------

// File: rtl/bus_slave_regs_if_pkg.sv
// Shared definitions for the bus responder: handshake levels, transfer direction,
// responder FSM states and the fixed register indices of the bank.
package bus_slave_regs_if_pkg;

    localparam int WORD_DATA_W = 32;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int SLV_REG_CTRL = 0;
    localparam int SLV_REG_STAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } slave_state_e;

    // The status slot reads from stat_in and swallows writes.
    function automatic logic is_stat_idx(input int idx);
        return idx == SLV_REG_STAT;
    endfunction

endpackage

// File: rtl/bus_slave_regs_if_regbank.sv
// Register bank behind the bus responder: one write port, one combinational read
// port, writes to the status slot dropped, word 0 exported for control.
module bus_slave_regs_if_regbank
    import bus_slave_regs_if_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wr_idx,
    input  logic [WORD_DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_idx,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic [WORD_DATA_W-1:0] word0
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_DATA_W-1:0] bank [DEPTH];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (we && !is_stat_idx(int'(wr_idx))) begin
            bank[wr_idx] <= wr_data;
        end
    end

    assign rd_data = bank[rd_idx];
    assign word0   = bank[SLV_REG_CTRL];

endmodule

// File: rtl/bus_slave_regs_if.sv
// Bus responder: accepts a chip-selected address strobe, waits WAIT_CYCLES, then
// answers with a one-cycle active-low ready and registered read data.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no transfer in flight; strobe with cs_ low is accepted
//  ST_WAIT    | request latched, wait counter running down to zero
//  ST_RESPOND | bus_rdy_ low for this one cycle, read data on bus_rd_data
module bus_slave_regs_if
    import bus_slave_regs_if_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int WAIT_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   bus_cs_,
    input  logic                   bus_as_,
    input  logic                   bus_rw,
    input  logic [31:0]            bus_addr,
    input  logic [WORD_DATA_W-1:0] bus_wr_data,
    output logic [WORD_DATA_W-1:0] bus_rd_data,
    output logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] stat_in,
    output logic [WORD_DATA_W-1:0] ctrl_out,
    output logic                   proto_err
);

    localparam logic [WAIT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);

    slave_state_e           state, state_nxt;
    logic [WAIT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0]      bus_idx, lat_idx, xfer_idx;
    logic                   lat_rw, xfer_rw;
    logic [WORD_DATA_W-1:0] lat_wdata, xfer_wdata;
    logic [WORD_DATA_W-1:0] bank_rd, rd_data_q, rd_data_nxt;
    logic                   strobe, accept, enter_resp, commit_we;
    logic                   proto_err_q;
    logic                   unused_addr_bits;

    assign bus_idx          = bus_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus_addr[31:ADDR_W+2], bus_addr[1:0]};
    assign strobe           = (bus_cs_ == ENABLE_) && (bus_as_ == ENABLE_);
    assign accept           = strobe && (state == ST_IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        enter_resp   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = ST_RESPOND;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt  = ST_RESPOND;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_ONE;
                end
            end
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so the
    // live bus values stand in for the not-yet-latched request.
    always_comb begin
        if (state == ST_IDLE) begin
            xfer_idx   = bus_idx;
            xfer_rw    = bus_rw;
            xfer_wdata = bus_wr_data;
        end else begin
            xfer_idx   = lat_idx;
            xfer_rw    = lat_rw;
            xfer_wdata = lat_wdata;
        end
    end

    assign commit_we = enter_resp && (xfer_rw == WRITE);

    always_comb begin
        rd_data_nxt = '0;
        if (enter_resp && (xfer_rw == READ)) begin
            rd_data_nxt = is_stat_idx(int'(xfer_idx)) ? stat_in : bank_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            lat_idx     <= '0;
            lat_rw      <= READ;
            lat_wdata   <= '0;
            rd_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            rd_data_q <= rd_data_nxt;
            if (accept) begin
                lat_idx   <= bus_idx;
                lat_rw    <= bus_rw;
                lat_wdata <= bus_wr_data;
            end
            if (strobe && (state != ST_IDLE)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    bus_slave_regs_if_regbank #(
        .ADDR_W (ADDR_W)
    ) u_regbank (
        .clk     (clk),
        .reset_  (reset_),
        .we      (commit_we),
        .wr_idx  (xfer_idx),
        .wr_data (xfer_wdata),
        .rd_idx  (xfer_idx),
        .rd_data (bank_rd),
        .word0   (ctrl_out)
    );

    assign bus_rdy_    = (state == ST_RESPOND) ? ENABLE_ : DISABLE_;
    assign bus_rd_data = rd_data_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_bus_slave_regs_if.sv
// Bench for bus_slave_regs_if: three instances (1, 0 and 3 wait states) driven by
// directed vectors, randomized transfers against a word-array model, and corner sequences.
module tb_bus_slave_regs_if;
    import bus_slave_regs_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        cs_n [3];
    logic        as_n [3];
    logic        rw   [3];
    logic [31:0] addr [3];
    logic [31:0] wdata[3];
    logic [31:0] rdata[3];
    logic [31:0] ctrl [3];
    logic        rdy  [3];
    logic        perr [3];
    logic [31:0] stat;

    int errors = 0;
    int checks = 0;

    logic [31:0] mbank [3][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_slave_regs_if #(
            .ADDR_W      (3),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .WAIT_W      (4)
        ) u_dut (
            .clk         (clk),
            .reset_      (reset_),
            .bus_cs_     (cs_n[g]),
            .bus_as_     (as_n[g]),
            .bus_rw      (rw[g]),
            .bus_addr    (addr[g]),
            .bus_wr_data (wdata[g]),
            .bus_rd_data (rdata[g]),
            .bus_rdy_    (rdy[g]),
            .stat_in     (stat),
            .ctrl_out    (ctrl[g]),
            .proto_err   (perr[g])
        );
    end

    function automatic int wc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: word-addressed array, status slot read from stat, writes there dropped.
    function automatic logic [31:0] model_xfer(input int d, input logic r, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [31:0] st);
        int idx = int'(a[4:2]);
        if (r == READ) return (idx == 1) ? st : mbank[d][idx];
        if (idx != 1) mbank[d][idx] = wd;
        return 32'h0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++) mbank[d][i] = 32'h0;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            cs_n[i] = 1'b1; as_n[i] = 1'b1; rw[i] = READ;
            addr[i] = 32'h0; wdata[i] = 32'h0;
        end
    endtask

    // One transfer; address and direction are scrambled after the strobe to prove
    // they are not re-sampled. Cycle 0 is the strobe cycle.
    task automatic run_xfer(input int d, input logic r, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int first = -1;
        int lows = 0;
        logic [31:0] bad_rd = 32'h0;
        logic rd_ok = 1'b1;
        @(negedge clk);
        cs_n[d] = 1'b0; as_n[d] = 1'b0; rw[d] = r; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        cs_n[d] = 1'b1; as_n[d] = 1'b1; rw[d] = ~r; addr[d] = ~a;
        for (int k = 1; k <= wc(d) + 3; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (rdy[d] === 1'b0) begin
                lows++;
                if (first < 0) first = k;
                if (rdata[d] !== exp_rd) begin rd_ok = 1'b0; bad_rd = rdata[d]; end
            end else if (rdata[d] !== 32'h0) begin
                rd_ok = 1'b0; bad_rd = rdata[d];
            end
        end
        check({tag, " ready_cycle"}, first, wc(d) + 1);
        check({tag, " ready_width"}, lows, 1);
        check({tag, " rd_data"}, rd_ok ? exp_rd : bad_rd, exp_rd);
        addr[d] = 32'h0; rw[d] = READ;
    endtask

    typedef struct {
        int          d;
        logic        r;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] st;
        logic [31:0] exp_rd;
        logic [31:0] exp_ctrl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] e;
        int lows;

        vecs[0] = '{0, WRITE, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{0, READ,  32'h0000_0000, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{0, WRITE, 32'h0000_0004, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{0, READ,  32'h0000_0004, 32'h0,         32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[4] = '{1, READ,  32'h0000_001C, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[5] = '{2, READ,  32'h0000_001C, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[6] = '{2, WRITE, 32'h0000_001C, 32'h600D_F00D, 32'h0,         32'h0,         32'h0};
        vecs[7] = '{2, READ,  32'hFFFF_FFFC, 32'h0,         32'h0,         32'h600D_F00D, 32'h0};
        vecs[8] = '{1, WRITE, 32'h8000_0003, 32'h1357_9BDF, 32'h0,         32'h0,         32'h1357_9BDF};
        vecs[9] = '{1, READ,  32'h0000_0000, 32'h0,         32'h0,         32'h1357_9BDF, 32'h1357_9BDF};

        idle_all();
        stat = 32'h0;
        model_reset();
        reset_ = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset rdy[%0d]", d), rdy[d], 1'b1);
            check($sformatf("reset rd_data[%0d]", d), rdata[d], 32'h0);
            check($sformatf("reset ctrl[%0d]", d), ctrl[d], 32'h0);
            check($sformatf("reset proto_err[%0d]", d), perr[d], 1'b0);
        end
        repeat (2) @(negedge clk);
        reset_ = 1'b1;

        foreach (vecs[i]) begin
            stat = vecs[i].st;
            e = model_xfer(vecs[i].d, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].st);
            run_xfer(vecs[i].d, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].exp_rd,
                     $sformatf("vec%0d", i));
            check($sformatf("vec%0d ctrl", i), ctrl[vecs[i].d], vecs[i].exp_ctrl);
            check($sformatf("vec%0d proto_err", i), perr[vecs[i].d], 1'b0);
        end

        for (int n = 0; n < 60; n++) begin
            int d = $urandom_range(0, 2);
            logic r = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            stat = $urandom;
            e = model_xfer(d, r, a, wd, stat);
            run_xfer(d, r, a, wd, e, $sformatf("rnd%0d", n));
            check($sformatf("rnd%0d ctrl", n), ctrl[d], mbank[d][0]);
        end

        // Second strobe while the first transfer waits: ignored, single ready, sticky error.
        @(negedge clk);
        cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = WRITE; addr[0] = 32'h8; wdata[0] = 32'h1111_1111;
        e = model_xfer(0, WRITE, 32'h8, 32'h1111_1111, stat);
        lows = 0;
        @(posedge clk); #1;
        addr[0] = 32'hC;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (k == 2) begin cs_n[0] = 1'b1; as_n[0] = 1'b1; end
            if (rdy[0] === 1'b0) lows++;
        end
        check("dup_strobe ready_count", lows, 1);
        check("dup_strobe proto_err", perr[0], 1'b1);
        e = model_xfer(0, READ, 32'h8, 32'h0, stat);
        run_xfer(0, READ, 32'h8, 32'h0, e, "dup_strobe rd_idx2");
        e = model_xfer(0, READ, 32'hC, 32'h0, stat);
        run_xfer(0, READ, 32'hC, 32'h0, e, "dup_strobe rd_idx3");
        check("proto_err sticky", perr[0], 1'b1);

        // Strobe without chip select: never accepted, no error.
        @(negedge clk);
        cs_n[2] = 1'b1; as_n[2] = 1'b0; rw[2] = WRITE; addr[2] = 32'h0; wdata[2] = 32'hBAD0_BAD0;
        @(negedge clk);
        as_n[2] = 1'b1;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rdy[2] === 1'b0) lows++;
        end
        check("no_cs ready_count", lows, 0);
        check("no_cs proto_err", perr[2], 1'b0);
        check("no_cs ctrl", ctrl[2], mbank[2][0]);

        // Reset during the wait of a write: abandoned, nothing committed, no ready.
        @(negedge clk);
        cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = WRITE; addr[0] = 32'h8; wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        cs_n[0] = 1'b1; as_n[0] = 1'b1;
        #2 reset_ = 1'b0;
        #1;
        check("midreset rdy", rdy[0], 1'b1);
        check("midreset rd_data", rdata[0], 32'h0);
        check("midreset ctrl", ctrl[0], 32'h0);
        check("midreset proto_err", perr[0], 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (rdy[0] === 1'b0) lows++;
        end
        check("midreset late_ready", lows, 0);
        e = model_xfer(0, READ, 32'h8, 32'h0, stat);
        run_xfer(0, READ, 32'h8, 32'h0, e, "midreset rd_idx2");
        check("midreset rd_idx2 model", e, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
